// File: rtl/i2c_target.sv
// I2C register-write target with open-drain SDA drive and a one-cycle write strobe.
// Defining I2C_TARGET_READ_EN adds the register read path (R/W=1 address accepted).
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'b0111001,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_sda_oe;
    logic                   r_busy;
    logic [7:0]             r_reg_addr;
    logic [7:0]             r_reg_wdata;
    logic                   r_reg_we;

    logic       w_scl;
    logic       w_sda;
    logic       w_start;
    logic       w_stop;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic [7:0] w_byte;
    logic       w_rw_ok;

    // Bus lines idle high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scl_sync <= {SYNC_STAGES{1'b1}};
            r_sda_sync <= {SYNC_STAGES{1'b1}};
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_scl_rise = ~r_scl_prev & w_scl;
    assign w_scl_fall = r_scl_prev & ~w_scl;
    assign w_byte     = {r_shift, w_sda};

`ifdef I2C_TARGET_READ_EN
    logic r_rw;
    logic r_mack;
    assign w_rw_ok = 1'b1;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
    assign w_rw_ok        = ~w_byte[0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            r_rw        <= 1'b0;
            r_mack      <= 1'b0;
`endif
        end else begin
            r_reg_we <= 1'b0;
            // The pointer advances in the cycle after the strobe, so the strobe sees the old value.
            if (r_reg_we) begin
                r_reg_addr <= r_reg_addr + 8'd1;
            end
            if (w_start || w_stop) begin
                r_state   <= w_start ? ADDR : IDLE;
                r_bit_cnt <= 3'd0;
                r_shift   <= 7'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
                r_mack    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ADDR, REG, WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == ADDR) begin
                                    if (w_byte[7:1] == ADDRESS && w_rw_ok) begin
                                        r_state <= ADDR_ACK;
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= IGNORE;
                                    end
`ifdef I2C_TARGET_READ_EN
                                    r_rw <= w_byte[0];
`endif
                                end else if (r_state == REG) begin
                                    r_reg_addr <= w_byte;
                                    r_state    <= REG_ACK;
                                end else begin
                                    r_reg_wdata <= w_byte;
                                    r_reg_we    <= 1'b1;
                                    r_state     <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK low, the second ends the ACK clock.
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= REG;
`ifdef I2C_TARGET_READ_EN
                                if (r_rw) begin
                                    r_shift   <= reg_rdata[6:0];
                                    r_sda_oe  <= ~reg_rdata[7];
                                    r_bit_cnt <= 3'd0;
                                    r_state   <= RDATA;
                                end
`endif
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= WDATA;
                            end
                        end
                    end
`ifdef I2C_TARGET_READ_EN
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_state    <= RDATA_ACK;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[5:0], 1'b0};
                        end
                    end
                    // SDA is released only on a falling edge so it never moves while SCL is high.
                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= IGNORE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_mack <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_mack) begin
                                r_mack    <= 1'b0;
                                r_shift   <= reg_rdata[6:0];
                                r_sda_oe  <= ~reg_rdata[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
`endif
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign busy      = r_busy;

endmodule
